// File: rtl/mcu_el2_dccm_init_seq.sv
// DCCM init sequencer: passes core bank traffic to the SRAM macros and, after reset
// or on request, takes over the banks to write zero data with a fixed ECC pattern.
module mcu_el2_dccm_init_seq #(
  parameter int                  NUM_BANKS = 4,
  parameter int                  ADDR_W    = 10,
  parameter int                  DATA_W    = 32,
  parameter int                  ECC_W     = 7,
  parameter logic [ECC_W-1:0]    ZERO_ECC  = {ECC_W{1'b0}},
  parameter bit                  AUTO_INIT = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          init_req,
  output logic                          init_busy,
  output logic                          init_done,
  output logic                          blocked_err,
  input  logic [NUM_BANKS-1:0]          core_clken,
  input  logic [NUM_BANKS-1:0]          core_wren,
  input  logic [NUM_BANKS*ADDR_W-1:0]   core_addr,
  input  logic [NUM_BANKS*DATA_W-1:0]   core_wr_data,
  input  logic [NUM_BANKS*ECC_W-1:0]    core_wr_ecc,
  output logic [NUM_BANKS*DATA_W-1:0]   core_dout,
  output logic [NUM_BANKS*ECC_W-1:0]    core_ecc,
  output logic [NUM_BANKS-1:0]          mem_clken,
  output logic [NUM_BANKS-1:0]          mem_wren,
  output logic [NUM_BANKS*ADDR_W-1:0]   mem_addr,
  output logic [NUM_BANKS*DATA_W-1:0]   mem_wr_data,
  output logic [NUM_BANKS*ECC_W-1:0]    mem_wr_ecc,
  input  logic [NUM_BANKS*DATA_W-1:0]   mem_dout,
  input  logic [NUM_BANKS*ECC_W-1:0]    mem_ecc
);

  typedef enum logic [1:0] {IDLE, GUARD, SWEEP} state_t;

  localparam state_t            RESET_STATE = AUTO_INIT ? SWEEP : IDLE;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = {ADDR_W{1'b1}};

  state_t            state;
  logic [ADDR_W-1:0] cnt;

  // GUARD gives a read issued in the last IDLE cycle time to return before the sweep.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= RESET_STATE;
      cnt         <= '0;
      init_busy   <= AUTO_INIT;
      init_done   <= 1'b0;
      blocked_err <= 1'b0;
    end else begin
      init_done <= 1'b0;
      if ((state != IDLE) && (|core_clken)) begin
        blocked_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (init_req) begin
            state     <= GUARD;
            init_busy <= 1'b1;
          end
        end
        GUARD: begin
          state <= SWEEP;
          cnt   <= '0;
        end
        SWEEP: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == LAST_ADDR) begin
            state     <= IDLE;
            init_busy <= 1'b0;
            init_done <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          init_busy <= 1'b0;
        end
      endcase
    end
  end

  // Bank mux is selected by state only, so init_req never reaches mem_* combinationally.
  always_comb begin
    mem_clken   = core_clken;
    mem_wren    = core_wren;
    mem_addr    = core_addr;
    mem_wr_data = core_wr_data;
    mem_wr_ecc  = core_wr_ecc;
    core_dout   = mem_dout;
    core_ecc    = mem_ecc;
    case (state)
      GUARD: begin
        mem_clken = '0;
        mem_wren  = '0;
      end
      SWEEP: begin
        mem_clken   = '1;
        mem_wren    = '1;
        mem_addr    = {NUM_BANKS{cnt}};
        mem_wr_data = '0;
        mem_wr_ecc  = {NUM_BANKS{ZERO_ECC}};
        core_dout   = '0;
        core_ecc    = '0;
      end
      default: ;
    endcase
  end

endmodule
